// File: rtl/fmes_seq_ctrl_if.sv
// fmes_seq_ctrl_if: control/datapath bundle of the frequency-meter sequencer.
// The master side is the controller/meter; the slave side is the sequencer.
interface fmes_seq_ctrl_if #(
    parameter int W_X = 16,
    parameter int W_Y = 24,
    parameter int W_Q = 16,
    parameter int W_F = 8
);
    logic           ce;
    logic           run;
    logic           single;
    logic           meas_st;
    logic           meas_end;
    logic           div_ok;
    logic [W_X-1:0] x_cnt;
    logic [W_Y-1:0] y_cnt;
    logic [W_Q-1:0] q_in;
    logic [W_F-1:0] f_in;
    logic [W_Q-1:0] q_out;
    logic [W_F-1:0] f_out;
    logic           res_vld;
    logic           busy;
    logic           no_sig;
    logic           ovf;

    modport master (
        output ce, run, single, meas_end, div_ok,
        output x_cnt, y_cnt, q_in, f_in,
        input  meas_st, q_out, f_out,
        input  res_vld, busy, no_sig, ovf
    );

    modport slave (
        input  ce, run, single, meas_end, div_ok,
        input  x_cnt, y_cnt, q_in, f_in,
        output meas_st, q_out, f_out,
        output res_vld, busy, no_sig, ovf
    );
endinterface

// File: rtl/fmes_seq_ctrl.sv
// fmes_seq_ctrl: measurement sequencer for the reciprocal frequency meter.
// Issues start, watches gate/divide phases with timeouts, latches results.
module fmes_seq_ctrl #(
    parameter int W_Q        = 16,
    parameter int W_F        = 8,
    parameter int TMO_TICKS  = 2000,
    parameter int DIV_TMO    = 255,
    parameter int HOLD_TICKS = 500
) (
    input  logic clk,
    input  logic rst_n,
    fmes_seq_ctrl_if.slave bus
);
    localparam int TMAXP = (TMO_TICKS > HOLD_TICKS) ? TMO_TICKS : HOLD_TICKS;
    localparam int TW    = $clog2(TMAXP + 1);
    localparam int DW    = $clog2(DIV_TMO + 1);

    localparam logic [TW-1:0] TMO_L  = TW'(TMO_TICKS);
    localparam logic [TW-1:0] HOLD_L = TW'(HOLD_TICKS);
    localparam logic [DW-1:0] DTMO_L = DW'(DIV_TMO);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_GATE, S_DIV, S_LATCH, S_HOLD
    } state_t;

    state_t         state;
    logic [TW-1:0]  tick_cnt;
    logic [TW-1:0]  tick_nxt;
    logic [DW-1:0]  div_cnt;
    logic           div_q;
    logic           div_edge;
    logic [W_Q-1:0] q_stg;
    logic [W_F-1:0] f_stg;
    logic [W_Q-1:0] q_r;
    logic [W_F-1:0] f_r;
    logic           meas_st_r;
    logic           res_vld_r;
    logic           busy_r;
    logic           no_sig_r;
    logic           ovf_r;

    assign tick_nxt = tick_cnt + 1'b1;
    assign div_edge = bus.div_ok & ~div_q;

    // Previous div_ok level; a stale high level never counts as done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= 1'b0;
        else        div_q <= bus.div_ok;
    end

    // Sequencer FSM with registered outputs and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            div_cnt   <= '0;
            q_stg     <= '0;
            f_stg     <= '0;
            q_r       <= '0;
            f_r       <= '0;
            meas_st_r <= 1'b0;
            res_vld_r <= 1'b0;
            busy_r    <= 1'b0;
            no_sig_r  <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            meas_st_r <= 1'b0;
            res_vld_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.single || bus.run) begin
                        state     <= S_ARM;
                        meas_st_r <= 1'b1;
                        busy_r    <= 1'b1;
                        no_sig_r  <= 1'b0;
                        ovf_r     <= 1'b0;
                    end
                end
                S_ARM: begin
                    tick_cnt <= '0;
                    state    <= S_GATE;
                end
                S_GATE: begin
                    if (bus.meas_end) begin
                        if (bus.x_cnt == '0) begin
                            no_sig_r <= 1'b1;
                            q_stg    <= '0;
                            f_stg    <= '0;
                            state    <= S_LATCH;
                        end else begin
                            div_cnt <= '0;
                            state   <= S_DIV;
                        end
                    end else if (bus.ce) begin
                        if (tick_cnt != '1) tick_cnt <= tick_nxt;
                        if (tick_nxt == TMO_L) begin
                            no_sig_r <= 1'b1;
                            q_stg    <= '0;
                            f_stg    <= '0;
                            state    <= S_LATCH;
                        end
                    end
                end
                S_DIV: begin
                    if (div_edge) begin
                        if (bus.y_cnt == '1) ovf_r <= 1'b1;
                        q_stg <= bus.q_in;
                        f_stg <= bus.f_in;
                        state <= S_LATCH;
                    end else if (div_cnt == DTMO_L) begin
                        ovf_r <= 1'b1;
                        q_stg <= '1;
                        f_stg <= '1;
                        state <= S_LATCH;
                    end else if (div_cnt != '1) begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    q_r       <= q_stg;
                    f_r       <= f_stg;
                    res_vld_r <= 1'b1;
                    tick_cnt  <= '0;
                    if (bus.run) begin
                        state <= S_HOLD;
                    end else begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!bus.run) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else if (bus.ce) begin
                        if (tick_cnt != '1) tick_cnt <= tick_nxt;
                        if (tick_nxt == HOLD_L) begin
                            state     <= S_ARM;
                            meas_st_r <= 1'b1;
                            no_sig_r  <= 1'b0;
                            ovf_r     <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.meas_st = meas_st_r;
    assign bus.res_vld = res_vld_r;
    assign bus.busy    = busy_r;
    assign bus.no_sig  = no_sig_r;
    assign bus.ovf     = ovf_r;
    assign bus.q_out   = q_r;
    assign bus.f_out   = f_r;
endmodule
